// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out of this bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow for a single bit position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles, start/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_borrow;
    logic [CntW-1:0]  r_cnt;
    logic             w_d;
    logic             w_bo;
    logic             w_accept;
    logic             w_last;

    full_subtractor u_full_subtractor (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bo)
    );

    // A request is taken whenever no operation is in flight (IDLE or the DONE cycle)
    assign w_accept = start && (r_state != StShift);
    assign w_last   = (r_cnt == CntW'(WIDTH - 1));

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) w_state_next = StShift;
            end
            StShift: begin
                busy = 1'b1;
                if (w_last) w_state_next = StDone;
            end
            StDone: begin
                done         = 1'b1;
                w_state_next = start ? StShift : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture on accept, then one bit per cycle through the subtractor cell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_br   <= bin;
            r_cnt  <= '0;
        end else if (r_state == StShift) begin
            r_res_sr <= {w_d, r_res_sr[WIDTH-1:1]};
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_br     <= w_bo;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Result registers update only as the last bit is processed, holding otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if ((r_state == StShift) && w_last) begin
            r_diff   <= {w_d, r_res_sr[WIDTH-1:1]};
            r_borrow <= w_bo;
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 and WIDTH=4 instances against a cycle-count reference model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       t_start [2];
    logic [7:0] t_a     [2];
    logic [7:0] t_b     [2];
    logic       t_bin   [2];
    logic       o_busy  [2];
    logic       o_done  [2];
    logic       o_bo    [2];
    logic [7:0] o_diff  [2];
    logic [7:0] w_diff8;
    logic [3:0] w_diff4;

    assign o_diff[0] = w_diff8;
    assign o_diff[1] = {4'h0, w_diff4};

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (t_start[0]),
        .a          (t_a[0]),
        .b          (t_b[0]),
        .bin        (t_bin[0]),
        .busy       (o_busy[0]),
        .done       (o_done[0]),
        .diff       (w_diff8),
        .borrow_out (o_bo[0])
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (t_start[1]),
        .a          (t_a[1][3:0]),
        .b          (t_b[1][3:0]),
        .bin        (t_bin[1]),
        .busy       (o_busy[1]),
        .done       (o_done[1]),
        .diff       (w_diff4),
        .borrow_out (o_bo[1])
    );

    function automatic int wid(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic int mask_of(input int k);
        return (1 << wid(k)) - 1;
    endfunction

    // Signed reference difference a - b - bin of the operands truncated to the instance width
    function automatic int ref_sub(input int k, input logic [7:0] a, input logic [7:0] b,
                                   input logic bin);
        return int'(a & 8'(mask_of(k))) - int'(b & 8'(mask_of(k))) - int'(bin);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request yields done and the arithmetic result WIDTH+1
    // cycles later; requests are dropped while a previous one is still counting down.
    int         m_rem  [2];
    logic       m_done [2];
    logic [7:0] m_diff [2];
    logic       m_bo   [2];
    logic [7:0] p_diff [2];
    logic       p_bo   [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_rem[k]  <= 0;
                m_done[k] <= 1'b0;
                m_diff[k] <= 8'h00;
                m_bo[k]   <= 1'b0;
                p_diff[k] <= 8'h00;
                p_bo[k]   <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_done[k] <= 1'b0;
                if (m_rem[k] > 0) begin
                    m_rem[k] <= m_rem[k] - 1;
                    if (m_rem[k] == 1) begin
                        m_done[k] <= 1'b1;
                        m_diff[k] <= p_diff[k];
                        m_bo[k]   <= p_bo[k];
                    end
                end else if (t_start[k]) begin
                    m_rem[k]  <= wid(k);
                    p_diff[k] <= 8'(ref_sub(k, t_a[k], t_b[k], t_bin[k]) & mask_of(k));
                    p_bo[k]   <= (ref_sub(k, t_a[k], t_b[k], t_bin[k]) < 0);
                end
            end
        end
    end

    // Compare process: every output of both instances, every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(m_rem[k] > 0));
                chk($sformatf("done%0d", k), 32'(o_done[k]), 32'(m_done[k]));
                chk($sformatf("diff%0d", k), 32'(o_diff[k]), 32'(m_diff[k]));
                chk($sformatf("borrow%0d", k), 32'(o_bo[k]), 32'(m_bo[k]));
            end
        end
    end

    task automatic wait_done(input int k, output int n);
        n = 0;
        while (!o_done[k] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", 32'(o_done[k]), 32'd1);
    endtask

    // One request from an idle instance; returns result and start-to-done cycle count
    task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                          input logic bin, output logic [7:0] d, output logic bo,
                          output int lat);
        int n;
        @(posedge clk);
        #1;
        t_a[k]     = a;
        t_b[k]     = b;
        t_bin[k]   = bin;
        t_start[k] = 1'b1;
        @(posedge clk);
        #1;
        t_start[k] = 1'b0;
        wait_done(k, n);
        lat = n + 1;
        d   = o_diff[k];
        bo  = o_bo[k];
    endtask

    initial begin
        logic [7:0] d;
        logic       bo;
        int         lat;
        int         n;
        int         r;

        for (int k = 0; k < 2; k++) begin
            t_start[k] = 1'b0;
            t_a[k]     = 8'h00;
            t_b[k]     = 8'h00;
            t_bin[k]   = 1'b0;
        end
        #1 rst_n = 1'b0;
        #20;
        chk("rst_busy", 32'(o_busy[0]), 32'd0);
        chk("rst_done", 32'(o_done[0]), 32'd0);
        chk("rst_diff", 32'(o_diff[0]), 32'd0);
        chk("rst_borrow", 32'(o_bo[0]), 32'd0);
        chk_en = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Hand-computed cases
        run_op(0, 8'd5, 8'd3, 1'b0, d, bo, lat);
        chk("5m3_diff", 32'(d), 32'h02);
        chk("5m3_borrow", 32'(bo), 32'd0);
        chk("5m3_latency", 32'(lat), 32'd9);
        run_op(0, 8'd3, 8'd5, 1'b0, d, bo, lat);
        chk("3m5_diff", 32'(d), 32'hFE);
        chk("3m5_borrow", 32'(bo), 32'd1);
        run_op(0, 8'd0, 8'd0, 1'b1, d, bo, lat);
        chk("0m0b_diff", 32'(d), 32'hFF);
        chk("0m0b_borrow", 32'(bo), 32'd1);

        // Start during SHIFT with different operands must be dropped
        @(posedge clk);
        #1;
        t_a[0] = 8'h40; t_b[0] = 8'h11; t_bin[0] = 1'b0; t_start[0] = 1'b1;
        @(posedge clk);
        #1 t_start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        t_a[0] = 8'h01; t_b[0] = 8'h02; t_bin[0] = 1'b1; t_start[0] = 1'b1;
        @(posedge clk);
        #1 t_start[0] = 1'b0;
        wait_done(0, n);
        chk("ignore_diff", 32'(o_diff[0]), 32'h2F);
        chk("ignore_borrow", 32'(o_bo[0]), 32'd0);

        // Reset at bit 4 aborts the operation and clears outputs at once
        @(posedge clk);
        #1;
        t_a[0] = 8'h99; t_b[0] = 8'h12; t_bin[0] = 1'b0; t_start[0] = 1'b1;
        @(posedge clk);
        #1 t_start[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(o_busy[0]), 32'd0);
        chk("abort_done", 32'(o_done[0]), 32'd0);
        chk("abort_diff", 32'(o_diff[0]), 32'd0);
        chk("abort_borrow", 32'(o_bo[0]), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_op(0, 8'h99, 8'h12, 1'b0, d, bo, lat);
        chk("after_rst_diff", 32'(d), 32'h87);
        chk("after_rst_borrow", 32'(bo), 32'd0);
        chk("after_rst_latency", 32'(lat), 32'd9);

        // Back-to-back: new start in the DONE cycle, no idle gap
        run_op(0, 8'd200, 8'd100, 1'b1, d, bo, lat);
        chk("b2b1_diff", 32'(d), 32'h63);
        chk("b2b1_borrow", 32'(bo), 32'd0);
        t_a[0] = 8'd10; t_b[0] = 8'd20; t_bin[0] = 1'b0; t_start[0] = 1'b1;
        @(posedge clk);
        #1 t_start[0] = 1'b0;
        chk("b2b_busy", 32'(o_busy[0]), 32'd1);
        chk("b2b_hold", 32'(o_diff[0]), 32'h63);
        wait_done(0, n);
        chk("b2b2_latency", 32'(n), 32'd8);
        chk("b2b2_diff", 32'(o_diff[0]), 32'hF6);
        chk("b2b2_borrow", 32'(o_bo[0]), 32'd1);

        // WIDTH=4 exhaustive sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run_op(1, 8'(ia), 8'(ib), 1'(ic), d, bo, lat);
                    r = ia - ib - ic;
                    chk($sformatf("exh_diff_%0d_%0d_%0d", ia, ib, ic), 32'(d), 32'(r & 15));
                    chk($sformatf("exh_borrow_%0d_%0d_%0d", ia, ib, ic), 32'(bo), 32'(r < 0));
                end
            end
        end

        // Random traffic on both instances, including starts while busy and in DONE
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                t_start[k] = ($urandom_range(3) == 0);
                t_a[k]     = 8'($urandom);
                t_b[k]     = 8'($urandom);
                t_bin[k]   = 1'($urandom);
            end
        end
        t_start[0] = 1'b0;
        t_start[1] = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
